// File: rtl/piso_sched.sv
// piso_sched: two-requester arbiter feeding a PISO serializer with one load strobe, WIDTH bit strobes
// (one every DIV clocks) and GAP idle bit-times. Define PISO_SCHED_FIXED_PRIO_EN for fixed priority (req0 first).
module piso_sched #(
  parameter int WIDTH = 32,
  parameter int DIV   = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] ser_data,
  output logic             ser_load,
  output logic             ser_shift_en,
  output logic             busy,
  output logic             done,
  output logic             gnt_id,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a requester raises reqN with dataN stable and holds both until ackN. Requests are only
  // sampled in IDLE; one withdrawn before then is never acked. ackN pulses in LOAD together with ser_load.

  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_CYC = (GAP > 0) ? GAP * DIV : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [GAP_W-1:0] r_gap;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_load;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_done;
  logic             r_gnt_id;
  logic [WIDTH-1:0] r_ser_data;

  logic w_any;
  logic w_win;  // 1: req1 wins this arbitration

  assign w_any = req0 | req1;

`ifdef PISO_SCHED_FIXED_PRIO_EN
  assign w_win = ~req0;
`else
  logic r_last;  // requester served most recently; reset value favours req0

  assign w_win = (req0 & req1) ? ~r_last : req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any) begin
      r_last <= w_win;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_load     <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gnt_id   <= 1'b0;
      r_ser_data <= '0;
    end else begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_load     <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_gnt_id   <= w_win;
            r_ser_data <= w_win ? data1 : data0;
            r_ack0     <= ~w_win;
            r_ack1     <= w_win;
            r_load     <= 1'b1;
            r_div      <= '0;
            r_bit      <= '0;
          end
        end
        S_LOAD: begin
          r_state <= S_SHIFT;
          r_div   <= '0;
          r_bit   <= '0;
          r_gap   <= '0;
        end
        S_SHIFT: begin
          // Strobe is registered, so it is set one clock ahead of the divider reaching DIV-1.
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_bit == BIT_LAST) begin
              r_done <= 1'b1;
              if (GAP > 0) begin
                r_state <= S_GAP;
                r_gap   <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_div      <= r_div + 1'b1;
            r_shift_en <= (r_div == DIV_PRE);
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign ser_data     = r_ser_data;
  assign ser_load     = r_load;
  assign ser_shift_en = r_shift_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign gnt_id       = r_gnt_id;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_piso_sched.sv
// Bench for piso_sched: directed frame/arbitration/reset scenarios plus random traffic against a
// frame-level timing model (ack at t, strobes every DIV cycles, done after the last strobe, idle after GAP).
`timescale 1ns/1ps
module tb_piso_sched;

  localparam int WIDTH     = 32;
  localparam int DIV       = 4;
  localparam int GAP       = 1;
  localparam int SHIFT_CYC = WIDTH * DIV;
  localparam int FRAME     = 1 + SHIFT_CYC + GAP * DIV;  // ack cycle to first idle cycle
  localparam int FRAME_G0  = 1 + SHIFT_CYC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic             ack0, ack1, ser_load, ser_shift_en, busy, done, gnt_id;
  logic [WIDTH-1:0] ser_data;
  logic [1:0]       dbg_state;

  logic             g_req0 = 1'b0, g_req1 = 1'b0;
  logic [WIDTH-1:0] g_data0 = '0, g_data1 = '0;
  logic             g_ack0, g_ack1, g_ser_load, g_ser_shift_en, g_busy, g_done, g_gnt_id;
  logic [WIDTH-1:0] g_ser_data;
  logic [1:0]       g_dbg_state;

  piso_sched #(.WIDTH(WIDTH), .DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .ser_data(ser_data), .ser_load(ser_load),
    .ser_shift_en(ser_shift_en), .busy(busy), .done(done), .gnt_id(gnt_id),
    .o_dbg_state(dbg_state)
  );

  piso_sched #(.WIDTH(WIDTH), .DIV(DIV), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .req0(g_req0), .req1(g_req1), .data0(g_data0), .data1(g_data1),
    .ack0(g_ack0), .ack1(g_ack1), .ser_data(g_ser_data), .ser_load(g_ser_load),
    .ser_shift_en(g_ser_shift_en), .busy(g_busy), .done(g_done), .gnt_id(g_gnt_id),
    .o_dbg_state(g_dbg_state)
  );

  wire [6:0] w_outs = {ack0, ack1, ser_load, ser_shift_en, busy, done, gnt_id};

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    #1;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = $urandom; data1 = $urandom;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (w_outs !== 7'd0 || ser_data !== '0 || dbg_state !== 2'd0)
        $display("FAIL reset_hold cyc%0d outs=%b ser_data=%h state=%0d required outs=0 ser_data=0 state=0",
                 i, w_outs, ser_data, dbg_state);
      else n_pass++;
    end
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    tick(); tick();
    n_total++;
    if (w_outs !== 7'd0) $display("FAIL reset_release outs=%b required 0", w_outs);
    else n_pass++;
  endtask

  task automatic test_single();
    int n_sh;
    logic exp_sh, exp_done, exp_busy;
    n_sh = 0;
    data0 = 32'h7FFFFFFE; req0 = 1'b1;
    tick();
    n_total++;
    if ({ack0, ack1, ser_load, busy, gnt_id} !== 5'b10110 || ser_data !== 32'h7FFFFFFE)
      $display("FAIL single_load ack0/ack1/load/busy/gnt=%b ser_data=%h required 10110 7ffffffe",
               {ack0, ack1, ser_load, busy, gnt_id}, ser_data);
    else n_pass++;
    req0 = 1'b0; data0 = $urandom;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      exp_sh   = (k % DIV == 0) && (k <= SHIFT_CYC);
      exp_done = (k == SHIFT_CYC + 1);
      exp_busy = (k < FRAME);
      if (ser_shift_en) n_sh++;
      n_total++;
      if ({ser_shift_en, done, busy, ser_load, ack0, ack1} !== {exp_sh, exp_done, exp_busy, 3'b000} ||
          ser_data !== 32'h7FFFFFFE)
        $display("FAIL single_trace t+%0d sh/done/busy/load/ack0/ack1=%b ser_data=%h required %b 7ffffffe",
                 k, {ser_shift_en, done, busy, ser_load, ack0, ack1}, ser_data,
                 {exp_sh, exp_done, exp_busy, 3'b000});
      else n_pass++;
    end
    n_total++;
    if (n_sh !== WIDTH) $display("FAIL single_shift_count got %0d required %0d", n_sh, WIDTH);
    else n_pass++;
  endtask

  task automatic test_busy_req();
    logic [WIDTH-1:0] a, b;
    a = $urandom; b = $urandom;
    data0 = a; req0 = 1'b1;
    tick();
    n_total++;
    if (ack0 !== 1'b1) $display("FAIL busyreq_ack0 got %b required 1", ack0);
    else n_pass++;
    req0 = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      if (k == 20) begin req1 = 1'b1; data1 = b; end
      n_total++;
      if (ack1 !== 1'b0 || ser_data !== a)
        $display("FAIL busyreq_hold t+%0d ack1=%b ser_data=%h required 0 %h", k, ack1, ser_data, a);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({ack1, ack0, gnt_id} !== 3'b101 || ser_data !== b)
      $display("FAIL busyreq_grant ack1/ack0/gnt=%b ser_data=%h required 101 %h", {ack1, ack0, gnt_id}, ser_data, b);
    else n_pass++;
    req1 = 1'b0;
    repeat (FRAME) tick();
  endtask

  task automatic test_drop();
    logic seen_ack1;
    seen_ack1 = 1'b0;
    data0 = $urandom; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int k = 1; k <= FRAME + 10; k++) begin
      tick();
      seen_ack1 |= ack1;
      if (k == 30) begin req1 = 1'b1; data1 = $urandom; end
      if (k == 60) req1 = 1'b0;
    end
    n_total++;
    if (seen_ack1 !== 1'b0 || busy !== 1'b0)
      $display("FAIL drop_no_ack seen_ack1=%b busy=%b required 0 0", seen_ack1, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] c;
    logic seen_done;
    seen_done = 1'b0;
    data0 = $urandom; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (50) tick();
    rst = 1'b0;
    #1;
    n_total++;
    if (w_outs !== 7'd0 || ser_data !== '0)
      $display("FAIL rstmid_immediate outs=%b ser_data=%h required 0 0", w_outs, ser_data);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen_done |= done;
    end
    n_total++;
    if (seen_done !== 1'b0 || w_outs !== 7'd0)
      $display("FAIL rstmid_no_done seen_done=%b outs=%b required 0 0", seen_done, w_outs);
    else n_pass++;
    c = $urandom; data0 = c; req0 = 1'b1;
    rst = 1'b1;
    tick();
    n_total++;
    if (ack0 !== 1'b1 || ser_data !== c)
      $display("FAIL rstmid_resume ack0=%b ser_data=%h required 1 %h", ack0, ser_data, c);
    else n_pass++;
    req0 = 1'b0;
    repeat (FRAME) tick();
  endtask

  task automatic test_contention();
    int exp_cyc;
    logic exp_last, exp_id, found;
    rst = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1; data0 = $urandom; data1 = $urandom;
    rst = 1'b1;
    exp_last = 1'b1;
    exp_cyc = cyc + 1;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int b = 0; b < FRAME + 4 && !found; b++) begin
        tick();
        if (ack0 || ack1) found = 1'b1;
      end
`ifdef PISO_SCHED_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = ~exp_last;
`endif
      n_total++;
      if (!found)
        $display("FAIL contention_timeout grant %0d no ack within %0d cycles", g, FRAME + 4);
      else if (cyc !== exp_cyc || {ack1, ack0} !== (exp_id ? 2'b10 : 2'b01) ||
               ser_data !== (exp_id ? data1 : data0))
        $display("FAIL contention grant %0d cyc=%0d ack1/ack0=%b ser_data=%h required cyc=%0d id=%0d data=%h",
                 g, cyc, {ack1, ack0}, ser_data, exp_cyc, exp_id, exp_id ? data1 : data0);
      else n_pass++;
      exp_last = exp_id;
      exp_cyc  = exp_cyc + FRAME + 1;
      if (exp_id) data1 = $urandom; else data0 = $urandom;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (FRAME) tick();
  endtask

  task automatic test_gap0();
    int t0;
    logic found;
    logic [WIDTH-1:0] d2;
    g_data0 = $urandom; g_req0 = 1'b1;
    tick();
    t0 = cyc;
    n_total++;
    if (g_ack0 !== 1'b1) $display("FAIL gap0_first_ack ack0=%b required 1", g_ack0);
    else n_pass++;
    d2 = $urandom; g_data0 = d2;
    found = 1'b0;
    for (int b = 0; b < FRAME_G0 + 4 && !found; b++) begin
      tick();
      if (g_done) found = 1'b1;
    end
    n_total++;
    if (!found || cyc !== t0 + SHIFT_CYC + 1)
      $display("FAIL gap0_done found=%b at t+%0d required t+%0d", found, cyc - t0, SHIFT_CYC + 1);
    else n_pass++;
    found = 1'b0;
    for (int b = 0; b < 8 && !found; b++) begin
      tick();
      if (g_ack0) found = 1'b1;
    end
    n_total++;
    if (!found || cyc !== t0 + SHIFT_CYC + 2 || g_ser_data !== d2)
      $display("FAIL gap0_next_ack found=%b at t+%0d ser_data=%h required t+%0d %h",
               found, cyc - t0, g_ser_data, SHIFT_CYC + 2, d2);
    else n_pass++;
    g_req0 = 1'b0;
    repeat (FRAME_G0) tick();
  endtask

  task automatic test_random();
    int next_free, exp_ack_cyc, last_ack, rel, c;
    logic last, exp_win, win, exp_sh, exp_done, exp_busy;
    logic [1:0] exp_ack;
    logic [WIDTH-1:0] exp_d;
    rst = 1'b0;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    next_free = cyc; last = 1'b1; last_ack = -100000; exp_ack_cyc = -1; exp_win = 1'b0;
    for (int s = 0; s < 3000; s++) begin
      tick();
      c = cyc;
      exp_ack = 2'b00;
      if (c == exp_ack_cyc) begin
        exp_ack  = exp_win ? 2'b10 : 2'b01;
        last_ack = c;
      end
      rel      = c - last_ack;
      exp_sh   = (rel > 0) && (rel <= SHIFT_CYC) && (rel % DIV == 0);
      exp_done = (rel == SHIFT_CYC + 1);
      exp_busy = (rel >= 0) && (rel < FRAME);
      n_total++;
      if ({ack1, ack0, ser_shift_en, done, busy, ser_load} !==
          {exp_ack, exp_sh, exp_done, exp_busy, exp_ack != 2'b00})
        $display("FAIL random_trace cyc%0d ack1/ack0/sh/done/busy/load=%b required %b", c,
                 {ack1, ack0, ser_shift_en, done, busy, ser_load},
                 {exp_ack, exp_sh, exp_done, exp_busy, exp_ack != 2'b00});
      else n_pass++;
      if (exp_ack != 2'b00) begin
        exp_d = exp_q.pop_front();
        n_total++;
        if (ser_data !== exp_d || gnt_id !== exp_win)
          $display("FAIL random_grant cyc%0d ser_data=%h gnt_id=%b required %h %b", c, ser_data, gnt_id, exp_d, exp_win);
        else n_pass++;
      end
      if (ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 9) == 0) begin req0 = 1'b1; data0 = $urandom; end
      if (ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 9) == 0) begin req1 = 1'b1; data1 = $urandom; end
      if (c >= next_free && (req0 || req1)) begin
`ifdef PISO_SCHED_FIXED_PRIO_EN
        win = !req0;
`else
        win = (req0 && req1) ? !last : req1;
`endif
        exp_win     = win;
        exp_ack_cyc = c + 1;
        exp_q.push_back(win ? data1 : data0);
        next_free   = c + 1 + FRAME;
        last        = win;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_busy_req();
    test_drop();
    test_reset_mid();
    test_contention();
    test_gap0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
